// File: rtl/sym_strip_gearbox.sv
// ---------------------------------------------------------------------------
// Module  : sym_strip_gearbox
// Brief   : Strips per-symbol overhead bits and repacks kept bits LSB-first
//           into OUT_W-bit words through a valid/ready gearbox buffer.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sym_strip_gearbox #(
  parameter int NSYM   = 8,
  parameter int SYM_W  = 10,
  parameter int KEEP_W = 8,
  parameter int OUT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NSYM*SYM_W-1:0]   in_data,
  input  logic                    in_last,
  input  logic                    chk_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_last,
  output logic                    err_pulse,
  output logic [15:0]             err_cnt
);

  localparam int PK_W   = NSYM * KEEP_W;
  localparam int ACC_W  = PK_W + OUT_W;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam int OVH_W  = SYM_W - KEEP_W;

  localparam logic [FILL_W-1:0] c_OUT_W = FILL_W'(OUT_W);
  localparam logic [FILL_W-1:0] c_PK_W  = FILL_W'(PK_W);

  logic [ACC_W-1:0]  r_acc;
  logic [FILL_W-1:0] r_fill;
  logic              r_flushing;
  logic              r_err_pulse;
  logic [15:0]       r_err_cnt;

  logic [PK_W-1:0]   w_pk;
  logic [NSYM-1:0]   w_ovh_nz;
  logic              w_push;
  logic              w_pop;
  logic [ACC_W-1:0]  w_shift_acc;
  logic [FILL_W-1:0] w_base;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic [FILL_W-1:0] w_fill_nxt;

  for (genvar k = 0; k < NSYM; k++) begin : g_sym
    assign w_pk[k*KEEP_W +: KEEP_W] = in_data[k*SYM_W +: KEEP_W];
    assign w_ovh_nz[k]              = |in_data[k*SYM_W+KEEP_W +: OVH_W];
  end

  // Handshake flags come from registered state only, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = !r_flushing && (r_fill <= c_OUT_W);
  assign out_valid = (r_fill >= c_OUT_W) || (r_flushing && (r_fill != '0));
  assign out_last  = r_flushing && (r_fill <= c_OUT_W);
  assign out_data  = r_acc[OUT_W-1:0];
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  // Bits above fill are kept at zero, so the shift supplies the padding and
  // the new packed beat can simply be OR-ed in at the post-pop fill level.
  always_comb begin
    w_shift_acc = r_acc;
    w_base      = r_fill;
    if (w_pop) begin
      w_shift_acc = r_acc >> OUT_W;
      w_base      = (r_fill >= c_OUT_W) ? (r_fill - c_OUT_W) : '0;
    end
    w_acc_nxt  = w_shift_acc;
    w_fill_nxt = w_base;
    if (w_push) begin
      w_acc_nxt  = w_shift_acc | (ACC_W'(w_pk) << w_base);
      w_fill_nxt = w_base + c_PK_W;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_fill      <= '0;
      r_flushing  <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_acc  <= w_acc_nxt;
      r_fill <= w_fill_nxt;
      if (w_push && in_last) begin
        r_flushing <= 1'b1;
      end else if (w_pop && out_last) begin
        r_flushing <= 1'b0;
      end
      r_err_pulse <= w_push && chk_en && (|w_ovh_nz);
      if (w_push && chk_en && (|w_ovh_nz) && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sym_strip_gearbox.sv
// ---------------------------------------------------------------------------
// Module  : tb_sym_strip_gearbox
// Brief   : Directed vector bench for sym_strip_gearbox (OUT_W=32 and 48).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sym_strip_gearbox;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        vld = 1'b0, lst = 1'b0, chk_en = 1'b0, ordy = 1'b0;
  logic [79:0] dat = '0;
  logic        ir, ov, ol, ep;
  logic [31:0] od;
  logic [15:0] ec;

  logic        vld2 = 1'b0, lst2 = 1'b0, ordy2 = 1'b0;
  logic [79:0] dat2 = '0;
  logic        ir2, ov2, ol2, ep2;
  logic [47:0] od2;
  logic [15:0] ec2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sym_strip_gearbox #(.NSYM(8), .SYM_W(10), .KEEP_W(8), .OUT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(vld), .in_ready(ir), .in_data(dat), .in_last(lst), .chk_en(chk_en),
    .out_valid(ov), .out_ready(ordy), .out_data(od), .out_last(ol),
    .err_pulse(ep), .err_cnt(ec)
  );

  sym_strip_gearbox #(.NSYM(8), .SYM_W(10), .KEEP_W(8), .OUT_W(48)) u_dut48 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(vld2), .in_ready(ir2), .in_data(dat2), .in_last(lst2), .chk_en(1'b0),
    .out_valid(ov2), .out_ready(ordy2), .out_data(od2), .out_last(ol2),
    .err_pulse(ep2), .err_cnt(ec2)
  );

  typedef struct {
    logic        vld;
    logic [79:0] dat;
    logic        lst;
    logic        chk;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_dat;
    logic        e_last;
    logic        e_ep;
    logic [15:0] e_ec;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [79:0] beat(input int first);
    logic [79:0] b;
    b = '0;
    for (int k = 0; k < 8; k++) b[k*10 +: 10] = 10'(first + k);
    return b;
  endfunction

  task automatic add(input logic v, input logic [79:0] d, input logic l, input logic c,
                     input logic r, input logic eir, input logic eov, input logic [31:0] edat,
                     input logic elast, input logic eep, input logic [15:0] eec);
    vec_t x;
    x.vld = v; x.dat = d; x.lst = l; x.chk = c; x.ordy = r;
    x.e_ir = eir; x.e_ov = eov; x.e_dat = edat; x.e_last = elast; x.e_ep = eep; x.e_ec = eec;
    tbl.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [79:0] d, input logic l, input logic c,
                       input logic r);
    vld = v; dat = d; lst = l; chk_en = c; ordy = r;
    @(negedge clk);
  endtask

  task automatic run_rows(input int lo, input int hi);
    vec_t x;
    for (int i = lo; i < hi; i++) begin
      x = tbl[i];
      chk($sformatf("row%0d in_ready", i), 64'(ir), 64'(x.e_ir));
      chk($sformatf("row%0d out_valid", i), 64'(ov), 64'(x.e_ov));
      chk($sformatf("row%0d out_data", i), 64'(od), 64'(x.e_dat));
      chk($sformatf("row%0d out_last", i), 64'(ol), 64'(x.e_last));
      chk($sformatf("row%0d err_pulse", i), 64'(ep), 64'(x.e_ep));
      chk($sformatf("row%0d err_cnt", i), 64'(ec), 64'(x.e_ec));
      drive(x.vld, x.dat, x.lst, x.chk, x.ordy);
    end
  endtask

  initial begin
    logic [79:0] bad;
    int t1_end, t2_end;
    bad = beat(1);
    bad[30 +: 10] = 10'h3FF;

    // Single frame, two words, out_last on the second.
    add(1, beat(1), 1, 0, 1,  1, 0, 32'h0,        0, 0, 16'd0);
    add(0, '0,      0, 0, 1,  0, 1, 32'h04030201, 0, 0, 16'd0);
    add(0, '0,      0, 0, 1,  0, 1, 32'h08070605, 1, 0, 16'd0);
    add(0, '0,      0, 0, 1,  1, 0, 32'h0,        0, 0, 16'd0);
    t1_end = tbl.size();
    // Four-beat stream; in_valid held so ignored beats are re-presented.
    add(1, beat(1),  0, 0, 1, 1, 0, 32'h0,        0, 0, 16'd0);
    add(1, beat(9),  0, 0, 1, 0, 1, 32'h04030201, 0, 0, 16'd0);
    add(1, beat(9),  0, 0, 1, 1, 1, 32'h08070605, 0, 0, 16'd0);
    add(1, beat(17), 0, 0, 1, 0, 1, 32'h0C0B0A09, 0, 0, 16'd0);
    add(1, beat(17), 0, 0, 1, 1, 1, 32'h100F0E0D, 0, 0, 16'd0);
    add(1, beat(25), 1, 0, 1, 0, 1, 32'h14131211, 0, 0, 16'd0);
    add(1, beat(25), 1, 0, 1, 1, 1, 32'h18171615, 0, 0, 16'd0);
    add(0, '0,       0, 0, 1, 0, 1, 32'h1C1B1A19, 0, 0, 16'd0);
    add(0, '0,       0, 0, 1, 0, 1, 32'h201F1E1D, 1, 0, 16'd0);
    // Overhead check enabled, then the same beat with check disabled, then a clean beat.
    add(1, bad,     1, 1, 1, 1, 0, 32'h0,        0, 0, 16'd0);
    add(0, '0,      0, 0, 1, 0, 1, 32'hFF030201, 0, 1, 16'd1);
    add(0, '0,      0, 0, 1, 0, 1, 32'h08070605, 1, 0, 16'd1);
    add(1, bad,     1, 0, 1, 1, 0, 32'h0,        0, 0, 16'd1);
    add(0, '0,      0, 0, 1, 0, 1, 32'hFF030201, 0, 0, 16'd1);
    add(0, '0,      0, 0, 1, 0, 1, 32'h08070605, 1, 0, 16'd1);
    add(1, beat(1), 1, 1, 1, 1, 0, 32'h0,        0, 0, 16'd1);
    add(0, '0,      0, 0, 1, 0, 1, 32'h04030201, 0, 0, 16'd1);
    add(0, '0,      0, 0, 1, 0, 1, 32'h08070605, 1, 0, 16'd1);
    add(0, '0,      0, 0, 1, 1, 0, 32'h0,        0, 0, 16'd1);
    t2_end = tbl.size();

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_rows(0, t2_end);

    // Backpressure: residue of 32 plus a full beat gives fill 96, then hold.
    chk("bp start in_ready", 64'(ir), 64'(1));
    drive(1, beat(1), 0, 0, 1);
    chk("bp w0", 64'(od), 64'h04030201);
    drive(1, beat(9), 1, 0, 1);
    chk("bp residue in_ready", 64'(ir), 64'(1));
    drive(1, beat(9), 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp hold%0d out_valid", i), 64'(ov), 64'(1));
      chk($sformatf("bp hold%0d in_ready", i), 64'(ir), 64'(0));
      chk($sformatf("bp hold%0d out_data", i), 64'(od), 64'h08070605);
      drive(0, '0, 0, 0, 0);
    end
    chk("bp drain0", 64'(od), 64'h08070605);
    chk("bp drain0 last", 64'(ol), 64'(0));
    drive(0, '0, 0, 0, 1);
    chk("bp drain1", 64'(od), 64'h0C0B0A09);
    chk("bp drain1 last", 64'(ol), 64'(0));
    drive(0, '0, 0, 0, 1);
    chk("bp drain2", 64'(od), 64'h100F0E0D);
    chk("bp drain2 last", 64'(ol), 64'(1));
    drive(0, '0, 0, 0, 1);
    chk("bp idle out_valid", 64'(ov), 64'(0));
    chk("bp idle in_ready", 64'(ir), 64'(1));

    // OUT_W=48: 128 kept bits give 48, 48, then 32 zero-padded bits.
    ordy2 = 1'b1;
    chk("w48 start in_ready", 64'(ir2), 64'(1));
    vld2 = 1; dat2 = beat(1); lst2 = 0; @(negedge clk);
    chk("w48 w0 valid", 64'(ov2), 64'(1));
    chk("w48 w0", 64'(od2), 64'h060504030201);
    chk("w48 w0 in_ready", 64'(ir2), 64'(0));
    vld2 = 1; dat2 = beat(9); lst2 = 1; @(negedge clk);
    chk("w48 residue out_valid", 64'(ov2), 64'(0));
    chk("w48 residue in_ready", 64'(ir2), 64'(1));
    @(negedge clk);
    vld2 = 0; lst2 = 0;
    chk("w48 w1", 64'(od2), 64'h0C0B0A090807);
    chk("w48 w1 last", 64'(ol2), 64'(0));
    @(negedge clk);
    chk("w48 w2 valid", 64'(ov2), 64'(1));
    chk("w48 w2", 64'(od2), 64'h0000100F0E0D);
    chk("w48 w2 last", 64'(ol2), 64'(1));
    @(negedge clk);
    chk("w48 idle out_valid", 64'(ov2), 64'(0));
    chk("w48 err_cnt", 64'(ec2), 64'(0));
    chk("w48 err_pulse", 64'(ep2), 64'(0));

    // Asynchronous reset mid-frame, then a clean replay of the first frame.
    drive(1, beat(1), 1, 0, 1);
    drive(0, '0, 0, 0, 1);
    chk("arst pre out_valid", 64'(ov), 64'(1));
    chk("arst pre err_cnt", 64'(ec), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst out_valid", 64'(ov), 64'(0));
    chk("arst in_ready", 64'(ir), 64'(1));
    chk("arst out_data", 64'(od), 64'(0));
    chk("arst err_cnt", 64'(ec), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_rows(0, t1_end);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
